// File: rtl/lcd_msg_arbiter_pkg.sv
// rtl/lcd_msg_arbiter_pkg.sv - shared constants and FSM state encoding for the LCD message arbiter
package lcd_msg_arbiter_pkg;

  // Number of requesters sharing the I2C controller
  localparam int NUM_REQ = 2;

  // Idle cycles after every message (LCD command settle time)
  localparam int DEF_GAP_CYCLES = 100;

  // Maximum cycles between a byte's issue and its acknowledge
  localparam int DEF_ACK_TIMEOUT = 1000;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_XFER  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/lcd_rr_arbiter.sv
// rtl/lcd_rr_arbiter.sv - two-way round-robin grant with last-served pointer
module lcd_rr_arbiter
  import lcd_msg_arbiter_pkg::*;
(
  input  logic               clk_50K,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] gnt
);

  // 1 when requester 1 was served last, so requester 0 wins the next tie
  logic last_served;

  // With both requesting, the one not served last wins; otherwise the lone requester
  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = last_served ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Remember who was served when a grant is taken; reset favours requester 0
  always_ff @(posedge clk_50K) begin
    if (!rstn) begin
      last_served <= 1'b1;
    end else if (update && (gnt != '0)) begin
      last_served <= gnt[1];
    end
  end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// rtl/lcd_msg_arbiter.sv - arbitrates two LCD message sources onto one I2C byte controller
module lcd_msg_arbiter
  import lcd_msg_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic               clk_50K,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic [3:0]         len0,
  input  logic [3:0]         len1,
  input  logic [7:0]         byte0,
  input  logic [7:0]         byte1,
  output logic [3:0]         byte_idx,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic               i2c_start,
  output logic [7:0]         i2c_data,
  output logic               i2c_last,
  input  logic               i2c_ack
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [2:0]         state;
  logic [3:0]         len_q;
  logic [GW-1:0]      gap_cnt;
  logic [TW-1:0]      tmo_cnt;
  logic               ack_q;
  logic               ack_edge;
  logic               at_last;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_update;
  logic [3:0]         win_len;

  assign ack_edge   = i2c_ack & ~ack_q;
  assign at_last    = (byte_idx == (len_q - 4'd1));
  assign arb_update = (state == ST_ARB);
  assign win_len    = arb_gnt[1] ? len1 : len0;
  assign i2c_start  = (state == ST_START);
  assign i2c_last   = (state == ST_XFER) && at_last;

  lcd_rr_arbiter u_rr (
    .clk_50K (clk_50K),
    .rstn    (rstn),
    .req     (req),
    .update  (arb_update),
    .gnt     (arb_gnt)
  );

  // Byte presented to the controller comes from whoever holds the grant
  always_comb begin
    i2c_data = 8'h00;
    if (grant[0]) begin
      i2c_data = byte0;
    end else if (grant[1]) begin
      i2c_data = byte1;
    end
  end

  // Previous ack level, so only a low-to-high transition advances a byte
  always_ff @(posedge clk_50K) begin
    if (!rstn) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= i2c_ack;
    end
  end

  // Message FSM: arbitrate, start, stream bytes on ack edges, then settle gap.
  // The timeout counter runs from the start pulse, when the first byte is already on i2c_data.
  always_ff @(posedge clk_50K) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      grant    <= '0;
      done     <= '0;
      err      <= '0;
      byte_idx <= 4'd0;
      len_q    <= 4'd0;
      gap_cnt  <= '0;
      tmo_cnt  <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        ST_IDLE: begin
          if (req != '0) state <= ST_ARB;
        end
        ST_ARB: begin
          byte_idx <= 4'd0;
          tmo_cnt  <= '0;
          gap_cnt  <= '0;
          if (arb_gnt == '0) begin
            state <= ST_IDLE;
          end else if (win_len == 4'd0) begin
            done  <= arb_gnt;
            state <= ST_GAP;
          end else begin
            grant <= arb_gnt;
            len_q <= win_len;
            state <= ST_START;
          end
        end
        ST_START: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          state   <= ST_XFER;
        end
        ST_XFER: begin
          if (ack_edge) begin
            tmo_cnt <= '0;
            if (byte_idx != 4'hF) byte_idx <= byte_idx + 4'd1;
            if (at_last) begin
              done  <= grant;
              grant <= '0;
              state <= ST_GAP;
            end
          end else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
            err   <= grant;
            grant <= '0;
            state <= ST_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// tb/tb_lcd_msg_arbiter.sv - randomized self-checking bench for lcd_msg_arbiter
module tb_lcd_msg_arbiter;
  import lcd_msg_arbiter_pkg::*;

  localparam int GAP    = DEF_GAP_CYCLES;
  localparam int ACK_TO = DEF_ACK_TIMEOUT;

  logic       clk_50K = 1'b0;
  logic       rstn;
  logic [1:0] req;
  logic [3:0] len0, len1;
  logic [7:0] byte0, byte1;
  logic [3:0] byte_idx;
  logic [1:0] grant, done, err;
  logic       i2c_start;
  logic [7:0] i2c_data;
  logic       i2c_last;
  logic       i2c_ack;

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];

  int n_cmp = 0;
  int n_mis = 0;
  int n_start = 0, n_done = 0, n_err = 0, n_last = 0, n_last_bad = 0;
  int last_idx_expect = 0;
  int rr_last = 1;

  always #10 clk_50K = ~clk_50K;

  assign byte0 = mem0[byte_idx];
  assign byte1 = mem1[byte_idx];

  lcd_msg_arbiter dut (
    .clk_50K   (clk_50K),
    .rstn      (rstn),
    .req       (req),
    .len0      (len0),
    .len1      (len1),
    .byte0     (byte0),
    .byte1     (byte1),
    .byte_idx  (byte_idx),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .i2c_start (i2c_start),
    .i2c_data  (i2c_data),
    .i2c_last  (i2c_last),
    .i2c_ack   (i2c_ack)
  );

  // Pulse and level counters observed away from the active edge
  always @(negedge clk_50K) begin
    if (i2c_start) n_start++;
    if (done != 2'b00) n_done++;
    if (err != 2'b00) n_err++;
    if (i2c_last) begin
      n_last++;
      if (int'(byte_idx) != last_idx_expect) n_last_bad++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50K);
  endtask

  task automatic do_reset();
    rstn = 1'b0; req = 2'b00; i2c_ack = 1'b0;
    tick(3);
    rstn = 1'b1;
    rr_last = 1;
    tick(1);
  endtask

  // Round-robin reference: a tie goes to whoever was not served last
  function automatic int model_winner(input logic [1:0] r);
    if (r == 2'b11) return (rr_last == 1) ? 0 : 1;
    return r[1] ? 1 : 0;
  endfunction

  task automatic wait_grant(output int k);
    k = 0;
    while (grant == 2'b00 && done == 2'b00 && k < 400) begin
      tick(1);
      k++;
    end
  endtask

  // Acts as requester and I2C controller for one whole message
  task automatic run_msg(input int dmin, input int dmax, input bit keep_req, output logic [1:0] seen);
    int w, n, k, gap_bad, d0, s0, e0;
    logic [1:0] eg;
    w = model_winner(req);
    eg = (w == 0) ? 2'b01 : 2'b10;
    n = (w == 0) ? int'(len0) : int'(len1);
    rr_last = w;
    last_idx_expect = n - 1;
    d0 = n_done; s0 = n_start; e0 = n_err;
    wait_grant(k);
    seen = grant | done;
    if (n == 0) begin
      chk("zlen_done", done, eg);
      chk("zlen_grant", grant, 2'b00);
      if (!keep_req) req[w] = 1'b0;
      tick(GAP);
      chk("zlen_no_start", n_start - s0, 0);
      chk("zlen_done_once", n_done - d0, 1);
    end else begin
      chk("grant", grant, eg);
      chk("start_with_grant", i2c_start, 1);
      for (int i = 0; i < n; i++) begin
        chk("byte_idx", byte_idx, i);
        chk("i2c_data", i2c_data, (w == 0) ? mem0[i] : mem1[i]);
        tick($urandom_range(dmax, dmin));
        chk("i2c_last", i2c_last, (i == n - 1) ? 1 : 0);
        i2c_ack = 1'b1;
        tick(1);
        i2c_ack = 1'b0;
      end
      chk("done", done, eg);
      chk("grant_drop", grant, 2'b00);
      if (!keep_req) req[w] = 1'b0;
      gap_bad = 0;
      for (int g = 1; g < GAP; g++) begin
        tick(1);
        if (grant != 2'b00) gap_bad++;
      end
      chk("gap_grant_low", gap_bad, 0);
      chk("done_once", n_done - d0, 1);
      chk("start_once", n_start - s0, 1);
      chk("no_err", n_err - e0, 0);
      chk("last_idx_ok", n_last_bad, 0);
    end
  endtask

  initial begin
    int k, d0, e0, s0, l0;
    logic [1:0] g1, g2, g3;
    len0 = 4'd0; len1 = 4'd0;
    for (int j = 0; j < 16; j++) begin mem0[j] = 8'($urandom); mem1[j] = 8'($urandom); end

    // Reset state
    do_reset();
    chk("rst_grant", grant, 2'b00);
    chk("rst_done_err", {done, err}, 4'h0);
    chk("rst_start", i2c_start, 0);
    chk("rst_byte_idx", byte_idx, 0);
    chk("rst_data_last", {i2c_data, i2c_last}, 9'h000);

    // Three-byte message from requester 0, ack 4 cycles after each byte
    mem0[0] = 8'h50; mem0[1] = 8'hFE; mem0[2] = 8'h51;
    len0 = 4'd3; req = 2'b01;
    l0 = n_last;
    run_msg(4, 4, 0, g1);
    chk("last_cycles", n_last - l0, 5);

    // Zero-length message
    len0 = 4'd0; req = 2'b01;
    run_msg(1, 1, 0, g1);

    // Ack ignored in START and a held-high ack advances only once
    len0 = 4'd2; req = 2'b01; rr_last = 0; last_idx_expect = 1;
    d0 = n_done;
    wait_grant(k);
    chk("hold_grant", grant, 2'b01);
    i2c_ack = 1'b1;
    tick(6);
    chk("hold_idx0", byte_idx, 0);
    i2c_ack = 1'b0; tick(1); i2c_ack = 1'b1; tick(1);
    chk("ack_idx1", byte_idx, 1);
    tick(5);
    chk("hold_idx1", byte_idx, 1);
    chk("hold_no_done", n_done - d0, 0);
    i2c_ack = 1'b0; tick(1); i2c_ack = 1'b1; tick(1);
    chk("hold_done", done, 2'b01);
    i2c_ack = 1'b0; req = 2'b00;
    tick(GAP + 4);

    // Acknowledge timeout on requester 1
    len1 = 4'd14; req = 2'b10; rr_last = 1; last_idx_expect = 13;
    d0 = n_done; e0 = n_err;
    wait_grant(k);
    chk("to_grant", grant, 2'b10);
    chk("to_start", i2c_start, 1);
    k = 0;
    while (err == 2'b00 && k < ACK_TO + 50) begin tick(1); k++; end
    chk("to_latency", k, ACK_TO);
    chk("to_err", err, 2'b10);
    chk("to_idx", byte_idx, 0);
    req = 2'b00;
    tick(GAP);
    chk("to_no_done", n_done - d0, 0);
    chk("to_err_once", n_err - e0, 1);
    tick(4);

    // Reset in the middle of a 14-byte message from requester 0
    for (int j = 0; j < 16; j++) mem0[j] = 8'($urandom);
    len0 = 4'd14; req = 2'b01; last_idx_expect = 13;
    wait_grant(k);
    chk("mid_grant", grant, 2'b01);
    for (int i = 0; i < 5; i++) begin
      tick(2);
      i2c_ack = 1'b1; tick(1); i2c_ack = 1'b0;
    end
    chk("mid_idx5", byte_idx, 5);
    d0 = n_done; e0 = n_err;
    rstn = 1'b0; req = 2'b00;
    tick(1);
    chk("mid_rst_outputs", {grant, done, err, i2c_start, byte_idx, i2c_data, i2c_last}, 0);
    rstn = 1'b1; rr_last = 1;
    tick(3);
    chk("mid_rst_no_pulse", (n_done - d0) + (n_err - e0), 0);
    len0 = 4'd2; len1 = 4'd3; req = 2'b11;
    run_msg(1, 3, 0, g1);
    chk("post_rst_winner", g1, 2'b01);
    run_msg(1, 3, 0, g2);
    req = 2'b00;

    // Both requesting continuously: strict alternation
    do_reset();
    len0 = 4'd2; len1 = 4'd2; req = 2'b11;
    run_msg(1, 3, 1, g1);
    run_msg(1, 3, 1, g2);
    run_msg(1, 3, 1, g3);
    chk("rr_order", {g1, g2, g3}, 6'b01_10_01);
    req = 2'b00;
    tick(4);

    // Randomized traffic against the reference model
    for (int m = 0; m < 24; m++) begin
      for (int j = 0; j < 16; j++) begin mem0[j] = 8'($urandom); mem1[j] = 8'($urandom); end
      len0 = ($urandom_range(7, 0) == 0) ? 4'd0 : 4'($urandom_range(6, 1));
      len1 = ($urandom_range(7, 0) == 0) ? 4'd0 : 4'($urandom_range(6, 1));
      req = 2'($urandom_range(3, 1));
      run_msg(1, 4, 0, g1);
      req = 2'b00;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
